// File: rtl/crc24_attach.sv
// rtl/crc24_attach.sv - serial LTE CRC24 attachment stage feeding the turbo interleaver
//
// Takes a code-block payload one bit per cycle, forwards it unchanged and
// appends the 24-bit CRC MSB first. Each block totals LONG_LEN or SHORT_LEN
// output bits, selected by in_block_size sampled with the start bit.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_start/in_data   payload bit stream; in_start marks bit 0
//   in_block_size               1=long, 0=short; sampled with the start bit
//   in_ready                    stage accepts a bit this cycle
//   CRC_valid/CRC_data          registered serial output (payload then CRC)
//   CRC_start                   pulse with the first output bit of a block
//   block_size                  latched block size, held until the next start
//   done                        pulse the cycle after the last CRC bit
//   err                         protocol-error pulse
module crc24_attach #(
   parameter int            LONG_LEN  = 6144,
   parameter int            SHORT_LEN = 1056,
   parameter int            CRC_W     = 24,
   parameter logic [23:0]   CRC_POLY  = 24'h864CFB,
   parameter int            CNT_W     = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_start,
   input  logic in_data,
   input  logic in_block_size,
   output logic in_ready,
   output logic CRC_valid,
   output logic CRC_data,
   output logic CRC_start,
   output logic block_size,
   output logic done,
   output logic err
);

   localparam int             CC_W     = $clog2(CRC_W);
   localparam logic [CC_W-1:0] CRC_LAST = CC_W'(CRC_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_APPEND, S_DONE} state_t;

   state_t             state, state_nx;
   logic [CRC_W-1:0]   crc, crc_nx;
   logic [CNT_W-1:0]   pay_cnt, pay_cnt_nx;
   logic [CC_W-1:0]    crc_cnt, crc_cnt_nx;
   logic               valid_nx, data_nx, start_nx, bs_nx, done_nx, err_nx;
   logic               accept;

   function automatic logic [CNT_W-1:0] pay_len_of(input logic bs);
      return bs ? CNT_W'(LONG_LEN - CRC_W) : CNT_W'(SHORT_LEN - CRC_W);
   endfunction

   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
      logic fb;
      fb = c[CRC_W-1] ^ b;
      return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY[CRC_W-1:0] : '0);
   endfunction

   assign accept = in_valid && in_ready;

   always_comb begin
      state_nx   = state;
      crc_nx     = crc;
      pay_cnt_nx = pay_cnt;
      crc_cnt_nx = crc_cnt;
      in_ready   = 1'b0;
      valid_nx   = 1'b0;
      data_nx    = 1'b0;
      start_nx   = 1'b0;
      bs_nx      = block_size;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (accept) begin
               if (in_start) begin
                  bs_nx      = in_block_size;
                  crc_nx     = crc_step('0, in_data);
                  pay_cnt_nx = CNT_W'(1);
                  crc_cnt_nx = '0;
                  valid_nx   = 1'b1;
                  data_nx    = in_data;
                  start_nx   = 1'b1;
                  state_nx   = (pay_len_of(in_block_size) == CNT_W'(1)) ? S_APPEND : S_PASS;
               end else begin
                  // Stray bit with no block open: dropped and flagged.
                  err_nx = 1'b1;
               end
            end
         end
         S_PASS: begin
            in_ready = 1'b1;
            if (accept) begin
               // A repeated start inside a block is kept as data.
               err_nx     = in_start;
               crc_nx     = crc_step(crc, in_data);
               pay_cnt_nx = pay_cnt + 1'b1;
               valid_nx   = 1'b1;
               data_nx    = in_data;
               if (pay_cnt + 1'b1 == pay_len_of(block_size)) begin
                  crc_cnt_nx = '0;
                  state_nx   = S_APPEND;
               end
            end
         end
         S_APPEND: begin
            // Shift the remainder out MSB first, directly behind the payload.
            valid_nx   = 1'b1;
            data_nx    = crc[CRC_W-1];
            crc_nx     = {crc[CRC_W-2:0], 1'b0};
            crc_cnt_nx = crc_cnt + 1'b1;
            if (crc_cnt == CRC_LAST) state_nx = S_DONE;
         end
         S_DONE: begin
            done_nx    = 1'b1;
            pay_cnt_nx = '0;
            crc_cnt_nx = '0;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         crc        <= '0;
         pay_cnt    <= '0;
         crc_cnt    <= '0;
         CRC_valid  <= 1'b0;
         CRC_data   <= 1'b0;
         CRC_start  <= 1'b0;
         block_size <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         crc        <= crc_nx;
         pay_cnt    <= pay_cnt_nx;
         crc_cnt    <= crc_cnt_nx;
         CRC_valid  <= valid_nx;
         CRC_data   <= data_nx;
         CRC_start  <= start_nx;
         block_size <= bs_nx;
         done       <= done_nx;
         err        <= err_nx;
      end
   end

endmodule

// File: tb/tb_crc24_attach.sv
// tb/tb_crc24_attach.sv - directed self-checking bench for crc24_attach
module tb_crc24_attach;

   logic clk = 1'b0;
   logic reset, in_valid, in_start, in_data, in_block_size;
   logic in_ready, CRC_valid, CRC_data, CRC_start, block_size, done, err;

   always #5 clk = ~clk;

   crc24_attach dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start),
      .in_data(in_data), .in_block_size(in_block_size), .in_ready(in_ready),
      .CRC_valid(CRC_valid), .CRC_data(CRC_data), .CRC_start(CRC_start),
      .block_size(block_size), .done(done), .err(err)
   );

   int n_chk = 0, n_pass = 0;
   int cyc = 0, first_cyc, last_cyc, done_cyc, start_cnt, start_at, done_cnt, err_cnt, bs_bad;
   bit seen, exp_bs;
   bit out_q[$], exp_q[$];
   int held_cyc, bubbles;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (CRC_valid) begin
         out_q.push_back(CRC_data);
         if (!seen) first_cyc = cyc;
         seen = 1'b1;
         last_cyc = cyc;
      end
      if (CRC_start) begin
         start_cnt = start_cnt + 1;
         start_at  = CRC_valid ? out_q.size() - 1 : -1;
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (err) err_cnt = err_cnt + 1;
      if ((CRC_valid || done) && block_size != exp_bs) bs_bad = bs_bad + 1;
   end

   task automatic clear_mon();
      out_q.delete(); exp_q.delete();
      seen = 1'b0; start_cnt = 0; start_at = -2; done_cnt = 0; err_cnt = 0; bs_bad = 0;
      first_cyc = 0; last_cyc = 0; done_cyc = 0;
   endtask

   function automatic logic [23:0] crc_of(input bit p[$]);
      logic [23:0] c = '0;
      logic fb;
      foreach (p[i]) begin
         fb = c[23] ^ p[i];
         c  = {c[22:0], 1'b0} ^ (fb ? 24'h864CFB : 24'h0);
      end
      return c;
   endfunction

   task automatic add_exp(input bit p[$]);
      logic [23:0] c;
      c = crc_of(p);
      foreach (p[i]) exp_q.push_back(p[i]);
      for (int i = 23; i >= 0; i--) exp_q.push_back(c[i]);
   endtask

   function automatic logic [23:0] tail24();
      logic [23:0] t = '0;
      if (out_q.size() >= 24)
         for (int i = 0; i < 24; i++) t = {t[22:0], out_q[out_q.size() - 24 + i]};
      return t;
   endfunction

   task automatic cmp_stream(input string tag);
      int bad = 0;
      chk({tag, " len"}, out_q.size(), exp_q.size());
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         if (out_q[i] != exp_q[i]) bad++;
      chk({tag, " bits"}, bad, 0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Drives n_send bits of p; in_start on bit 0 and on bit restart_at.
   task automatic drive_block(input bit bs, input bit p[$], input int n_send,
                              input bit bub, input int restart_at);
      int k = 0;
      held_cyc = 0;
      bubbles  = 0;
      for (int i = 0; i < n_send; i++) begin
         if (bub && (k % 7 == 6)) begin
            in_valid = 1'b0; tick(); k++; bubbles++;
         end
         in_valid = 1'b1; in_start = (i == 0) || (i == restart_at);
         in_data = p[i]; in_block_size = bs;
         while (!in_ready && held_cyc < 200) begin tick(); held_cyc++; end
         tick(); k++;
      end
      in_valid = 1'b0; in_start = 1'b0; in_data = 1'b0;
   endtask

   task automatic wait_done(input int n, input string tag);
      int w = 0;
      while (done_cnt < n && w < 400) begin tick(); w++; end
      repeat (3) tick();
      chk({tag, " done count"}, done_cnt, n);
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_data = 1'b0; in_block_size = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
   endtask

   bit p[$], pb[$];

   initial begin
      do_reset();
      chk("reset outs", {26'b0, CRC_valid, CRC_data, CRC_start, block_size, done, err}, 0);
      chk("reset in_ready", in_ready, 1);

      // 1: short block of zeros, continuous
      p.delete(); for (int i = 0; i < 1032; i++) p.push_back(1'b0);
      clear_mon(); exp_bs = 0;
      drive_block(0, p, 1032, 0, -1);
      wait_done(1, "t1");
      chk("t1 len", out_q.size(), 1056);
      chk("t1 contiguous", last_cyc - first_cyc + 1, 1056);
      chk("t1 start count", start_cnt, 1);
      chk("t1 start pos", start_at, 0);
      chk("t1 crc", tail24(), 24'h000000);
      chk("t1 done timing", done_cyc, last_cyc + 1);
      chk("t1 block_size", bs_bad, 0);
      chk("t1 err", err_cnt, 0);

      // 2: 1031 zeros then a one -> CRC equals the polynomial
      p[1031] = 1'b1;
      clear_mon(); exp_bs = 0;
      drive_block(0, p, 1032, 0, -1);
      wait_done(1, "t2");
      chk("t2 len", out_q.size(), 1056);
      chk("t2 crc", tail24(), 24'h864CFB);

      // 3: long random block with a bubble every 7th cycle
      p.delete(); for (int i = 0; i < 6120; i++) p.push_back(1'($urandom));
      clear_mon(); exp_bs = 1; add_exp(p);
      drive_block(1, p, 6120, 1, -1);
      wait_done(1, "t3");
      cmp_stream("t3");
      chk("t3 bubbles", (last_cyc - first_cyc + 1) - out_q.size(), bubbles);
      chk("t3 crc", tail24(), crc_of(p));
      chk("t3 block_size", bs_bad, 0);
      chk("t3 start count", start_cnt, 1);

      // 4: stray bit in IDLE, then a repeated start at bit 500
      p.delete(); for (int i = 0; i < 1032; i++) p.push_back(1'($urandom));
      clear_mon(); exp_bs = 0; add_exp(p);
      in_valid = 1'b1; in_start = 1'b0; in_data = 1'b1; tick();
      in_valid = 1'b0;
      drive_block(0, p, 1032, 0, 500);
      wait_done(1, "t4");
      chk("t4 err count", err_cnt, 2);
      cmp_stream("t4");
      chk("t4 start count", start_cnt, 1);

      // 5: reset at payload bit 300 of a long block, then a fresh short block
      p.delete(); for (int i = 0; i < 6120; i++) p.push_back(1'($urandom));
      clear_mon(); exp_bs = 1;
      drive_block(1, p, 300, 0, -1);
      reset = 1'b1; tick();
      chk("t5 outs in reset", {26'b0, CRC_valid, CRC_data, CRC_start, block_size, done, err}, 0);
      reset = 1'b0;
      repeat (40) tick();
      chk("t5 aborted done", done_cnt, 0);
      chk("t5 aborted len", out_q.size(), 300);
      p.delete(); for (int i = 0; i < 1032; i++) p.push_back(1'($urandom));
      clear_mon(); exp_bs = 0; add_exp(p);
      drive_block(0, p, 1032, 0, -1);
      wait_done(1, "t5");
      cmp_stream("t5");
      chk("t5 block_size", bs_bad, 0);

      // 6: back-to-back short blocks, second start held through APPEND/DONE
      p.delete(); pb.delete();
      for (int i = 0; i < 1032; i++) begin p.push_back(1'($urandom)); pb.push_back(1'($urandom)); end
      clear_mon(); exp_bs = 0; add_exp(p); add_exp(pb);
      drive_block(0, p, 1032, 0, -1);
      chk("t6 first held", held_cyc, 0);
      drive_block(0, pb, 1032, 0, -1);
      chk("t6 second held", held_cyc, 25);
      wait_done(2, "t6");
      cmp_stream("t6");
      chk("t6 start count", start_cnt, 2);
      chk("t6 second start pos", start_at, 1056);
      chk("t6 err", err_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
